// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator execution sequencer:
//   - operator codes carried on op_code / op_held
//   - FSM state encoding used by calc_exec_sequencer
//   - small helper to classify operators that need the iterative unit
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OP_HELD = 3'd1,
    ST_EXEC    = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  // MUL and DIV share the multi-cycle shift unit; ADD and SUB do not.
  function automatic logic is_iter_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/calc_iter_muldiv.sv
// -----------------------------------------------------------------------------
// calc_iter_muldiv
// WIDTH-cycle iterative unit: shift-add multiply or restoring divide.
// Ports:
//   clock, reset_n  clock / asynchronous active-low reset
//   start           1-cycle strobe: load a, b and begin iterating
//   abort           drop any operation in flight (takes priority over start)
//   is_div          with start: 1 = divide a/b, 0 = multiply a*b
//   a, b            operands, sampled with start
//   done            high during the final iteration cycle
//   value           with done: product low half, or quotient
//   ovf             with done (multiply only): product high half is nonzero
// The outputs present the value the final iteration is about to register, so
// the consumer can capture the result on the same edge that completes it.
// -----------------------------------------------------------------------------
module calc_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] hi_q,    hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q,    lo_d;   // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opd_q,   opd_d;  // multiplicand / divisor
  logic             div_q,   div_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             last;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opd_d  = opd_q;
    div_d  = div_q;

    // Multiply step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);

    // Divide step: shift the next dividend bit into the remainder and try to
    // subtract. Two guard bits make the sign of the trial unambiguous.
    div_trial = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, opd_q};

    if (div_q) begin
      if (div_trial[WIDTH+1]) begin
        step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = a;
      opd_d  = b;
      div_d  = is_div;
    end else if (busy_q) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opd_q  <= opd_d;
      div_q  <= div_d;
    end
  end

  assign done  = busy_q && last;
  assign value = step_lo;
  assign ovf   = !div_q && (step_hi != '0);

endmodule

// File: rtl/calc_exec_sequencer.sv
// -----------------------------------------------------------------------------
// calc_exec_sequencer
// Holds the selected operator and, on '=', executes A op B and hands the result
// back to the A register via a one-cycle load strobe.
// Ports:
//   clock, reset_n   clock / asynchronous active-low reset
//   op_valid/op_code operator key strobe and code (ADD, SUB, MUL, DIV)
//   eq_in            '=' key strobe
//   clear_in         clear/abort strobe, highest priority in every state
//   a_in, b_in       operand register values, sampled on accepted '='
//   busy             high while executing (keypad input blocked)
//   op_pending       high while an operator is held awaiting '='
//   op_held          currently held operator code
//   result           last result, qualified by load_result
//   load_result      1-cycle strobe: write result into A
//   err_overflow     sticky overflow flag (until clear_in)
//   err_div0         sticky divide-by-zero flag (until clear_in)
// Timing: ADD/SUB spend one cycle in EXEC, MUL/DIV spend WIDTH cycles. The
// result is registered on leaving EXEC, and load_result is registered out of
// DONE, so it appears two cycles (ADD/SUB) or WIDTH+1 cycles (MUL/DIV) after
// the edge that accepts '='.
// -----------------------------------------------------------------------------
module calc_exec_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             eq_in,
  input  logic             clear_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             op_pending,
  output logic [1:0]       op_held,
  output logic [WIDTH-1:0] result,
  output logic             load_result,
  output logic             err_overflow,
  output logic             err_div0
);

  state_e           state_q,   state_d;
  logic [1:0]       op_held_q, op_held_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             load_q,    load_d;
  logic             ovf_q,     ovf_d;
  logic             div0_q,    div0_d;

  logic             iter_start;
  logic             iter_abort;
  logic             iter_done;
  logic [WIDTH-1:0] iter_value;
  logic             iter_ovf;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;

  // The iterative unit samples a_in/b_in directly on the accepting edge so its
  // first iteration lines up with the first EXEC cycle.
  calc_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (iter_start),
    .abort   (iter_abort),
    .is_div  (op_held_q == OP_DIV),
    .a       (a_in),
    .b       (b_in),
    .done    (iter_done),
    .value   (iter_value),
    .ovf     (iter_ovf)
  );

  always_comb begin
    state_d    = state_q;
    op_held_d  = op_held_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    load_d     = 1'b0;
    ovf_d      = ovf_q;
    div0_d     = div0_q;
    iter_start = 1'b0;
    iter_abort = 1'b0;

    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = a_q - b_q;

    if (clear_in) begin
      state_d    = ST_IDLE;
      op_held_d  = OP_ADD;
      result_d   = '0;
      ovf_d      = 1'b0;
      div0_d     = 1'b0;
      iter_abort = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            state_d   = ST_OP_HELD;
            op_held_d = op_code;
          end
        end

        ST_OP_HELD: begin
          // '=' wins over a coincident operator key; that key is dropped.
          if (eq_in) begin
            state_d    = ST_EXEC;
            a_d        = a_in;
            b_d        = b_in;
            iter_start = is_iter_op(op_held_q);
          end else if (op_valid) begin
            op_held_d = op_code;
          end
        end

        ST_EXEC: begin
          unique case (op_held_q)
            OP_ADD: begin
              if (add_sum[WIDTH]) begin
                state_d  = ST_ERROR;
                ovf_d    = 1'b1;
                result_d = '0;
              end else begin
                state_d  = ST_DONE;
                result_d = add_sum[WIDTH-1:0];
              end
            end
            OP_SUB: begin
              if (a_q < b_q) begin
                state_d  = ST_ERROR;
                ovf_d    = 1'b1;
                result_d = '0;
              end else begin
                state_d  = ST_DONE;
                result_d = sub_diff;
              end
            end
            OP_MUL: begin
              if (iter_done) begin
                if (iter_ovf) begin
                  state_d  = ST_ERROR;
                  ovf_d    = 1'b1;
                  result_d = '0;
                end else begin
                  state_d  = ST_DONE;
                  result_d = iter_value;
                end
              end
            end
            default: begin  // OP_DIV
              // A zero divisor is caught in the first EXEC cycle and the
              // iterative unit is stopped before it does any useful work.
              if (b_q == '0) begin
                state_d    = ST_ERROR;
                div0_d     = 1'b1;
                result_d   = '0;
                iter_abort = 1'b1;
              end else if (iter_done) begin
                state_d  = ST_DONE;
                result_d = iter_value;
              end
            end
          endcase
        end

        ST_DONE: begin
          load_d  = 1'b1;
          state_d = ST_IDLE;
        end

        ST_ERROR: begin
          result_d = '0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_held_q <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      load_q    <= 1'b0;
      ovf_q     <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_held_q <= op_held_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      load_q    <= load_d;
      ovf_q     <= ovf_d;
      div0_q    <= div0_d;
    end
  end

  assign busy         = (state_q == ST_EXEC);
  assign op_pending   = (state_q == ST_OP_HELD);
  assign op_held      = op_held_q;
  assign result       = result_q;
  assign load_result  = load_q;
  assign err_overflow = ovf_q;
  assign err_div0     = div0_q;

endmodule
